// File: rtl/mgt_01_i_wb_arbiter_pkg.sv
// Shared types and constants for the integer register-file writeback arbiter.
// Writeback source indices, default sizing, register names and the data bus type.
package mgt_01_i_wb_arbiter_pkg;

  localparam int REQUESTERS_DEF  = 4;
  localparam int WRITE_PORTS_DEF = 2;

  localparam int WB_ALU = 0;
  localparam int WB_MUL = 1;
  localparam int WB_DIV = 2;
  localparam int WB_LSU = 3;

  typedef logic [31:0] data_bus_t;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;

endpackage

// File: rtl/mgt_01_i_wb_arbiter_if.sv
// Writeback request bus (sources -> arbiter) and register-file write ports.
// slave is the arbiter side, master is the requester / register-file side.
interface mgt_01_i_wb_arbiter_if #(
  parameter int REQUESTERS  = mgt_01_i_wb_arbiter_pkg::REQUESTERS_DEF,
  parameter int WRITE_PORTS = mgt_01_i_wb_arbiter_pkg::WRITE_PORTS_DEF
);
  import mgt_01_i_wb_arbiter_pkg::*;

  logic [REQUESTERS-1:0]  req_valid_i;
  i_register_e            req_addr_i [REQUESTERS];
  data_bus_t              req_data_i [REQUESTERS];
  logic [REQUESTERS-1:0]  req_ready_o;
  logic [WRITE_PORTS-1:0] we_o;
  i_register_e            wr_iaddr_o [WRITE_PORTS];
  data_bus_t              wr_idata_o [WRITE_PORTS];

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i,
    output req_ready_o, we_o, wr_iaddr_o, wr_idata_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i,
    input  req_ready_o, we_o, wr_iaddr_o, wr_idata_o
  );

endinterface

// File: rtl/mgt_01_i_wb_arbiter_rr_pick.sv
// Finds the first set bit of elig_i at or after start_i, wrapping modulo N.
// Purely combinational; found_o low when no bit is set.
module mgt_01_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  int            j;
  logic [IW-1:0] pos;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      pos = IW'(j);
      if (!found_o && elig_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/mgt_01_i_wb_arbiter.sv
// Writeback arbiter: grants up to WRITE_PORTS sources per cycle, one registered stage to the regfile.
// ready is combinational (sources stall until granted); MGT_01_WB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module mgt_01_i_wb_arbiter
  import mgt_01_i_wb_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = REQUESTERS_DEF,
  parameter int WRITE_PORTS = WRITE_PORTS_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clk_en_i,
  mgt_01_i_wb_arbiter_if.slave    wb
);

  localparam int IW = $clog2(REQUESTERS);

  logic [IW-1:0]                  start_idx;
  logic [REQUESTERS-1:0]          base_elig;
  logic [REQUESTERS-1:0]          grant;
  logic [REQUESTERS-1:0]          ready;
  logic [WRITE_PORTS-1:0]         found;
  logic [WRITE_PORTS-1:0][IW-1:0] pick_idx;

  logic [WRITE_PORTS-1:0]         we_d,    we_q;
  i_register_e                    waddr_d [WRITE_PORTS];
  i_register_e                    waddr_q [WRITE_PORTS];
  data_bus_t                      wdata_d [WRITE_PORTS];
  data_bus_t                      wdata_q [WRITE_PORTS];

`ifdef MGT_01_WB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    for (int n = 0; n < WRITE_PORTS; n++) begin
      if (found[n]) begin
        ptr_d = (pick_idx[n] == IW'(REQUESTERS - 1)) ? '0 : pick_idx[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign start_idx = ptr_q;
`else
  assign start_idx = '0;
`endif

  // X0 writes are acknowledged outside the port allocation, so they never enter the pick chain.
  always_comb begin
    base_elig = '0;
    for (int r = 0; r < REQUESTERS; r++) begin
      base_elig[r] = clk_en_i & wb.req_valid_i[r] & (wb.req_addr_i[r] != X0);
    end
  end

  for (genvar g = 0; g < WRITE_PORTS; g++) begin : g_port
    logic [REQUESTERS-1:0] elig_in;
    logic [REQUESTERS-1:0] elig_out;
    logic [IW-1:0]         idx;
    logic                  fnd;

    if (g == 0) begin : g_first
      assign elig_in = base_elig;
    end else begin : g_next
      assign elig_in = g_port[g-1].elig_out;
    end

    mgt_01_rr_pick #(.N(REQUESTERS)) u_pick (
      .elig_i  (elig_in),
      .start_i (start_idx),
      .idx_o   (idx),
      .found_o (fnd)
    );

    // Removes the winner and every later source aiming at the same register.
    always_comb begin
      elig_out = elig_in;
      for (int r = 0; r < REQUESTERS; r++) begin
        if (fnd && (wb.req_addr_i[r] == wb.req_addr_i[idx])) elig_out[r] = 1'b0;
      end
    end

    assign found[g]    = fnd;
    assign pick_idx[g] = idx;
  end

  always_comb begin
    grant = '0;
    for (int n = 0; n < WRITE_PORTS; n++) begin
      we_d[n]    = found[n];
      waddr_d[n] = X0;
      wdata_d[n] = '0;
      if (found[n]) begin
        grant[pick_idx[n]] = 1'b1;
        waddr_d[n]         = wb.req_addr_i[pick_idx[n]];
        wdata_d[n]         = wb.req_data_i[pick_idx[n]];
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int r = 0; r < REQUESTERS; r++) begin
      ready[r] = rst_n_i & clk_en_i & wb.req_valid_i[r] &
                 ((wb.req_addr_i[r] == X0) | grant[r]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q <= '0;
      for (int n = 0; n < WRITE_PORTS; n++) begin
        waddr_q[n] <= X0;
        wdata_q[n] <= '0;
      end
    end else begin
      we_q <= we_d;
      for (int n = 0; n < WRITE_PORTS; n++) begin
        waddr_q[n] <= waddr_d[n];
        wdata_q[n] <= wdata_d[n];
      end
    end
  end

  assign wb.req_ready_o = ready;
  assign wb.we_o        = we_q;
  assign wb.wr_iaddr_o  = waddr_q;
  assign wb.wr_idata_o  = wdata_q;

endmodule

// File: tb/tb_mgt_01_i_wb_arbiter.sv
// Scoreboard bench for the writeback arbiter: a reference scan model predicts ready and the registered writes.
module tb_mgt_01_i_wb_arbiter;
  import mgt_01_i_wb_arbiter_pkg::*;

  localparam int R = 4;
  localparam int W = 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b1;

  always #5 clk = ~clk;

  mgt_01_i_wb_arbiter_if #(.REQUESTERS(R), .WRITE_PORTS(W)) wb ();

  mgt_01_i_wb_arbiter #(.REQUESTERS(R), .WRITE_PORTS(W)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .clk_en_i (clk_en),
    .wb       (wb)
  );

  typedef struct packed {
    logic [W-1:0]       we;
    logic [W-1:0][4:0]  addr;
    logic [W-1:0][31:0] data;
  } exp_t;

  exp_t       sb [$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         m_ptr = 0;
  int         m_ptr_nxt = 0;
  logic [R-1:0] m_rdy;
  logic [R-1:0] obs_rdy;
  exp_t       m_exp;
  int         cnt [R];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: linear scan from the pointer, X0 acks free, ports filled in scan order.
  task automatic model();
    int          used;
    int          i;
    logic        dup;
    logic [4:0]  taken [W];
    m_rdy     = '0;
    m_exp     = '0;
    used      = 0;
    m_ptr_nxt = m_ptr;
    for (int u = 0; u < W; u++) taken[u] = '0;
    for (int k = 0; k < R; k++) begin
      i = (m_ptr + k) % R;
      if (clk_en && rst_n && wb.req_valid_i[i]) begin
        if (wb.req_addr_i[i] == X0) begin
          m_rdy[i] = 1'b1;
        end else if (used < W) begin
          dup = 1'b0;
          for (int u = 0; u < used; u++) if (taken[u] == wb.req_addr_i[i]) dup = 1'b1;
          if (!dup) begin
            taken[used]       = wb.req_addr_i[i];
            m_rdy[i]          = 1'b1;
            m_exp.we[used]    = 1'b1;
            m_exp.addr[used]  = wb.req_addr_i[i];
            m_exp.data[used]  = wb.req_data_i[i];
            used++;
`ifdef MGT_01_WB_ROUND_ROBIN_EN
            m_ptr_nxt = (i + 1) % R;
`endif
          end
        end
      end
    end
  endtask

  // Called just after a negedge with inputs already set; returns at the next negedge.
  task automatic cycle(input string tag);
    exp_t e;
    #1;
    model();
    obs_rdy = wb.req_ready_o;
    chk($sformatf("%s.ready", tag), 64'(obs_rdy), 64'(m_rdy));
    sb.push_back(m_exp);
    @(posedge clk);
    #1;
    m_ptr = m_ptr_nxt;
    e = sb.pop_front();
    chk($sformatf("%s.we", tag), 64'(wb.we_o), 64'(e.we));
    for (int n = 0; n < W; n++) begin
      chk($sformatf("%s.addr%0d", tag, n), 64'(wb.wr_iaddr_o[n]), 64'(e.addr[n]));
      chk($sformatf("%s.data%0d", tag, n), 64'(wb.wr_idata_o[n]), 64'(e.data[n]));
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int s, input logic v, input i_register_e a, input data_bus_t d);
    wb.req_valid_i[s] = v;
    wb.req_addr_i[s]  = a;
    wb.req_data_i[s]  = d;
  endtask

  task automatic clear_all();
    for (int s = 0; s < R; s++) set_req(s, 1'b0, X0, '0);
  endtask

  task automatic load_distinct();
    for (int s = 0; s < R; s++) set_req(s, 1'b1, i_register_e'(5'(s + 1)), 32'hA000_0000 + 32'(s));
  endtask

  initial begin
    clear_all();
    rst_n  = 1'b0;
    clk_en = 1'b1;
    load_distinct();
    repeat (2) @(negedge clk);
    #1;
    chk("reset.ready", 64'(wb.req_ready_o), 64'(4'b0000));
    chk("reset.we",    64'(wb.we_o),        64'(2'b00));
    for (int n = 0; n < W; n++) begin
      chk($sformatf("reset.addr%0d", n), 64'(wb.wr_iaddr_o[n]), 64'(X0));
      chk($sformatf("reset.data%0d", n), 64'(wb.wr_idata_o[n]), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    clear_all();

    // single source
    set_req(1, 1'b1, X5, 32'hDEADBEEF);
    cycle("single");
    chk("single.rdy_dir",  64'(obs_rdy),          64'(4'b0010));
    chk("single.we_dir",   64'(wb.we_o),          64'(2'b01));
    chk("single.addr_dir", 64'(wb.wr_iaddr_o[0]), 64'(X5));
    chk("single.data_dir", 64'(wb.wr_idata_o[0]), 64'(32'hDEADBEEF));
    clear_all();

    // asynchronous reset mid-cycle while a write is in the output stage
    load_distinct();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.ready", 64'(wb.req_ready_o), 64'(4'b0000));
    chk("midrst.we",    64'(wb.we_o),        64'(2'b00));
    chk("midrst.addr0", 64'(wb.wr_iaddr_o[0]), 64'(X0));
    chk("midrst.data0", 64'(wb.wr_idata_o[0]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;

    // all four sources continuously valid on x1..x4
    for (int s = 0; s < R; s++) cnt[s] = 0;
    for (int c = 0; c < 4; c++) begin
      cycle($sformatf("fair%0d", c));
      if (c == 0) chk("fair.first", 64'(obs_rdy), 64'(4'b0011));
      for (int s = 0; s < R; s++) if (obs_rdy[s]) begin
        cnt[s]++;
        wb.req_data_i[s] = wb.req_data_i[s] + 32'h100;
      end
    end
`ifdef MGT_01_WB_ROUND_ROBIN_EN
    for (int s = 0; s < R; s++) chk($sformatf("fair.cnt%0d", s), 64'(cnt[s]), 64'(2));
`else
    for (int s = 0; s < R; s++) chk($sformatf("fair.cnt%0d", s), 64'(cnt[s]), 64'((s < 2) ? 4 : 0));
`endif
    clear_all();

    // same-address collision
    set_req(0, 1'b1, X7, 32'h1111_0000);
    set_req(2, 1'b1, X7, 32'h2222_0000);
    cycle("coll0");
    chk("coll.first", 64'(obs_rdy), 64'(4'b0001));
    set_req(0, 1'b0, X0, '0);
    cycle("coll1");
    chk("coll.second", 64'(obs_rdy), 64'(4'b0100));
    chk("coll.data",   64'(wb.wr_idata_o[0]), 64'(32'h2222_0000));
    clear_all();

    // X0 acknowledgement alongside two real writes
    set_req(3, 1'b1, X0, 32'hBAD0_BAD0);
    set_req(0, 1'b1, X8, 32'h0000_0008);
    set_req(1, 1'b1, X9, 32'h0000_0009);
    cycle("x0");
    chk("x0.rdy_dir", 64'(obs_rdy), 64'(4'b1011));
    chk("x0.we_dir",  64'(wb.we_o), 64'(2'b11));
    chk("x0.a0_dir",  64'(wb.wr_iaddr_o[0]), 64'(X8));
    chk("x0.a1_dir",  64'(wb.wr_iaddr_o[1]), 64'(X9));
    clear_all();

    // clock enable low with requests pending
    load_distinct();
    clk_en = 1'b0;
    for (int c = 0; c < 3; c++) cycle($sformatf("cen%0d", c));
    clk_en = 1'b1;
    cycle("cen_resume");
`ifdef MGT_01_WB_ROUND_ROBIN_EN
    chk("cen.resume", 64'(obs_rdy), 64'(4'b1100));
`else
    chk("cen.resume", 64'(obs_rdy), 64'(4'b0011));
`endif
    clear_all();

    // random traffic honouring the hold-until-ready protocol
    for (int c = 0; c < 300; c++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      for (int s = 0; s < R; s++) begin
        if (!wb.req_valid_i[s] || m_rdy[s]) begin
          set_req(s, ($urandom_range(0, 3) != 0),
                  i_register_e'(5'($urandom_range(0, 7))), data_bus_t'($urandom));
        end
      end
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
